// File: rtl/sub_bytes_serial.sv
// Iterative AES SubBytes over a 128-bit state, LANES bytes per cycle.
// Optional macro SUB_BYTES_SERIAL_CLEAR_EN hides and clears residual state data.

module aes_sbox (
    input  logic [7:0] value,
    output logic [7:0] result
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    logic [7:0] power;
    logic [7:0] inverse;

    // Multiplicative inverse as value^254 (the product of value^(2^k) for k=1..7), then the affine map.
    always_comb begin
        power   = value;
        inverse = 8'h01;
        for (int k = 1; k < 8; k++) begin
            power   = gf_mul(power, power);
            inverse = gf_mul(inverse, power);
        end
        result = inverse
               ^ {inverse[6:0], inverse[7]}
               ^ {inverse[5:0], inverse[7:6]}
               ^ {inverse[4:0], inverse[7:5]}
               ^ {inverse[3:0], inverse[7:4]}
               ^ 8'h63;
    end

endmodule

module sub_bytes_serial #(
    parameter int LANES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int STEPS = 16 / LANES;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sub_bytes_serial: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        fsm;
    state_t        fsm_next;
    logic [CW-1:0] cnt;
    logic [127:0]  state_q;
    logic [127:0]  state_sub;
    logic [3:0]    lane_idx [LANES];
    logic [7:0]    sub_in   [LANES];
    logic [7:0]    sub_out  [LANES];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        aes_sbox u_sbox (
            .value  (sub_in[g]),
            .result (sub_out[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) fsm <= IDLE;
        else     fsm <= fsm_next;
    end

    always_comb begin
        fsm_next  = fsm;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (fsm)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) fsm_next = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (cnt == LAST) fsm_next = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) fsm_next = IDLE;
            end
            default: fsm_next = IDLE;
        endcase
    end

    // Lane l works on byte cnt*LANES+l; byte 0 sits in the top bits of the state.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_idx[l] = 4'(int'(cnt) * LANES + l);
            sub_in[l]   = 8'h00;
            for (int b = 0; b < 16; b++) begin
                if (lane_idx[l] == 4'(b)) sub_in[l] = state_q[127-8*b -: 8];
            end
        end
    end

    always_comb begin
        state_sub = state_q;
        for (int l = 0; l < LANES; l++) begin
            for (int b = 0; b < 16; b++) begin
                if (lane_idx[l] == 4'(b)) state_sub[127-8*b -: 8] = sub_out[l];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
            cnt     <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        state_q <= in_data;
                        cnt     <= '0;
                    end
                end
                BUSY: begin
                    state_q <= state_sub;
                    cnt     <= (cnt == LAST) ? '0 : cnt + 1'b1;
                end
                DONE: begin
`ifdef SUB_BYTES_SERIAL_CLEAR_EN
                    if (out_ready) state_q <= '0;
`endif
                end
                default: ;
            endcase
        end
    end

`ifdef SUB_BYTES_SERIAL_CLEAR_EN
    assign out_data = out_valid ? state_q : '0;
`else
    assign out_data = state_q;
`endif

endmodule

// File: doc/sub_bytes_serial.md
Name: sub_bytes_serial

Overview:
- Iterative AES SubBytes engine for a full 128-bit state.
- Accepts one state over a valid/ready handshake and substitutes LANES bytes per cycle through LANES instances of the existing byte sbox.
- Returns the substituted state over a second valid/ready handshake.
- Sits between the AddRoundKey output and ShiftRows in the area-optimised AES datapath, directly feeding the sbox instances.

Parameters:
- LANES, 1, number of sbox instances used in parallel. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream state is valid
- in_ready  out  1  block can accept a state
- in_data  in  128  input state; byte 0 = [127:120] … byte 15 = [7:0]
- out_valid  out  1  substituted state available
- out_ready  in  1  downstream accepts the state
- out_data  out  128  substituted state, same byte order as in_data
- busy  out  1  high in BUSY and DONE

Behaviour:
- One clock domain: clk. Reset rst is synchronous and active-high.
- Reset values: in_ready=1, out_valid=0, busy=0, out_data=0; internal state register=0; byte counter=0; FSM=IDLE.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture in_data into the state register, clear the counter, go to BUSY.
- BUSY:
  - in_ready=0.
  - Each cycle, bytes [cnt*LANES … cnt*LANES+LANES-1] of the state register are replaced by their sbox outputs, and cnt increments.
  - When cnt reaches 16/LANES-1, that substitution completes and the FSM goes to DONE.
- DONE:
  - out_valid=1 and out_data = state register.
  - On out_valid&&out_ready, go to IDLE.
- Latency: the accepting edge is cycle 0; out_valid rises after exactly 16/LANES further edges (16 for LANES=1, 1 for LANES=16).
- Throughput: one state per 16/LANES+2 cycles. There is no overlap, because in_ready is low in BUSY and in DONE.
- Counter width is clog2(16/LANES), minimum 1 bit. It wraps to 0 when entering DONE.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_valid stay stable indefinitely.
- in_valid asserted in BUSY or DONE is ignored. Upstream must hold it, per the handshake.
- out_ready asserted outside DONE has no effect.
- out_data outside DONE reflects the partially substituted register. It is meaningful only while out_valid=1.
- Reset asserted in any state, including mid-BUSY, wins over all other events. On the next edge every output takes its reset value and the partial state is discarded.
- Reset asserted on the same edge as an input or output handshake: reset wins, nothing is captured, nothing is counted as delivered.
- The sbox instances are purely combinational. No pipeline registers are inserted around them.

Optional Feature:
- Macro: SUB_BYTES_SERIAL_CLEAR_EN.
- Defined:
  - On the edge that completes the output handshake, the state register is zeroed. out_data therefore reads 0 in IDLE.
  - In BUSY, unprocessed bytes of the register are not exposed: out_data is forced to 0 whenever out_valid=0.
  - Purpose: residual-data hygiene.
- Undefined:
  - The state register keeps its last value after the handshake.
  - out_data always equals the state register.

Test Plan:
1. LANES=1: send 00112233445566778899aabbccddeeff with out_ready=1 -> out_valid rises exactly 16 edges after acceptance, with out_data=638293c31bfc33f5c4eeacea4bc12816.
2. LANES=4: send an all-zero state -> out_valid after 4 edges, out_data=6363…63 (16 bytes); in_ready returns to 1 one cycle after the handshake.
3. Backpressure: after DONE, hold out_ready=0 for 10 cycles while pulsing in_valid with ffff…ff -> out_data stays stable, in_ready=0, the second state is not captured. Then release out_ready -> IDLE, and the ff state is accepted, giving 1616…16.
4. Reset mid-op: LANES=1, assert rst at BUSY cycle 7 -> next edge gives out_valid=0, in_ready=1, busy=0, out_data=0; a following state completes in the full 16 cycles.
5. Back-to-back: stream 3 states with in_valid and out_ready held high -> outputs come in order, spaced 16/LANES+2 cycles apart, with no duplicates or drops.
6. With SUB_BYTES_SERIAL_CLEAR_EN: after the handshake of test 1, out_data=0 in IDLE. During BUSY, out_data=0. Without the macro, out_data in IDLE still reads 638293c31bfc33f5c4eeacea4bc12816.
